// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if -- handshake/status bundle for param_sync_fifo.
//
// Parameters:
//   DEPTH       number of FIFO entries; sets the width of count
//   DATA_WIDTH  bits per entry
//
// Signals:
//   w_en, data_in              write request and write data (master -> fifo)
//   r_en                       read request / pop            (master -> fifo)
//   data_out, valid_out        read data and its qualifier   (fifo -> master)
//   full, empty                occupancy flags               (fifo -> master)
//   almost_full, almost_empty  threshold flags               (fifo -> master)
//   count                      occupancy, 0..DEPTH           (fifo -> master)
//   overflow, underflow        one-cycle error pulses        (fifo -> master)
//
// Modports: master (the producer/consumer side), slave (the FIFO itself).
interface param_sync_fifo_if #(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned DATA_WIDTH = 8
) ();

  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CountW-1:0]     count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en,
    output data_in,
    output r_en,
    input  data_out,
    input  valid_out,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  w_en,
    input  data_in,
    input  r_en,
    output data_out,
    output valid_out,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo -- single-clock parameterised FIFO.
//
// Parameters:
//   DEPTH       storage entries (power of two, >= 4)
//   DATA_WIDTH  bits per entry
//   AF_THRESH   almost_full when count >= AF_THRESH
//   AE_THRESH   almost_empty when count <= AE_THRESH
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (takes priority over w_en / r_en)
//   bus  param_sync_fifo_if.slave: write/read handshake, data, flags, count, error pulses
//
// Build option:
//   SYNC_FIFO_FWFT_EN  when defined, first-word-fall-through: data_out shows the head entry
//                      combinationally whenever the FIFO is not empty, r_en pops it, and
//                      valid_out = !empty. When undefined (default), data_out is a register
//                      loaded on each accepted read and valid_out pulses the cycle after.
//
// Pointers carry one extra wrap bit so all DEPTH entries are usable; full/empty and count
// come straight from the registered pointers. Storage is never cleared by reset.
module param_sync_fifo #(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4
) (
  input logic                clk,
  input logic                rst,
  param_sync_fifo_if.slave   bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [PtrW-1:0] AfThr = PtrW'(AF_THRESH);
  localparam logic [PtrW-1:0] AeThr = PtrW'(AE_THRESH);

  // Storage
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointer state
  logic [PtrW-1:0] w_ptr_q, w_ptr_d;
  logic [PtrW-1:0] r_ptr_q, r_ptr_d;

  // Error pulses
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Derived status
  logic            full;
  logic            empty;
  logic [PtrW-1:0] count;
  logic            wr_accept;
  logic            rd_accept;
  logic [DATA_WIDTH-1:0] head_data;

  // Status derived only from registered pointers, so a write at edge N is visible after N.
  always_comb begin
    count = w_ptr_q - r_ptr_q;
    empty = (w_ptr_q == r_ptr_q);
    full  = (w_ptr_q[PtrW-1] != r_ptr_q[PtrW-1]) &&
            (w_ptr_q[AddrW-1:0] == r_ptr_q[AddrW-1:0]);
  end

  // Acceptance uses pre-edge flags: full+r_en reads only, empty+w_en writes only.
  always_comb begin
    wr_accept = bus.w_en && !full && !rst;
    rd_accept = bus.r_en && !empty && !rst;
  end

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    overflow_d  = bus.w_en && full;
    underflow_d = bus.r_en && empty;
    if (wr_accept) begin
      w_ptr_d = w_ptr_q + PtrW'(1);
    end
    if (rd_accept) begin
      r_ptr_d = r_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset: stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[w_ptr_q[AddrW-1:0]] <= bus.data_in;
    end
  end

  assign head_data = mem_q[r_ptr_q[AddrW-1:0]];

`ifdef SYNC_FIFO_FWFT_EN

  // Head entry falls through; forced to zero while empty so reset output is defined.
  always_comb begin
    bus.data_out  = empty ? '0 : head_data;
    bus.valid_out = !empty;
  end

`else

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;

  always_comb begin
    data_out_d = data_out_q;
    valid_d    = rd_accept;
    if (rd_accept) begin
      data_out_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    bus.data_out  = data_out_q;
    bus.valid_out = valid_q;
  end

`endif

  always_comb begin
    bus.full         = full;
    bus.empty        = empty;
    bus.count        = count;
    bus.almost_full  = (count >= AfThr);
    bus.almost_empty = (count <= AeThr);
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

`ifndef SYNTHESIS
  // Occupancy can never exceed the storage size.
  count_in_range_a : assert property (@(posedge clk) disable iff (rst)
    count <= PtrW'(DEPTH));
  // full and empty describe disjoint pointer states.
  flags_exclusive_a : assert property (@(posedge clk) disable iff (rst)
    !(full && empty));
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo -- directed self-checking bench for param_sync_fifo
// (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1). Works in both read modes;
// mode-specific expectations are selected by SYNC_FIFO_FWFT_EN.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DEPTH(8), .DATA_WIDTH(8)) bus ();

  param_sync_fifo #(
    .DEPTH      (8),
    .DATA_WIDTH (8),
    .AF_THRESH  (6),
    .AE_THRESH  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-data check before the popping edge (FWFT only).
  task automatic pre_read(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check({tag, ".data"}, 32'(bus.data_out), 32'(exp));
    check({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
`endif
  endtask

  // Read-data check after the popping edge (standard mode only).
  task automatic post_read(input string tag, input logic [7:0] exp);
`ifndef SYNC_FIFO_FWFT_EN
    check({tag, ".data"}, 32'(bus.data_out), 32'(exp));
    check({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'd0);
    check({tag, ".empty"}, 32'(bus.empty), 32'd1);
    check({tag, ".full"}, 32'(bus.full), 32'd0);
    check({tag, ".ae"}, 32'(bus.almost_empty), 32'd1);
    check({tag, ".af"}, 32'(bus.almost_full), 32'd0);
    check({tag, ".data_out"}, 32'(bus.data_out), 32'd0);
    check({tag, ".valid"}, 32'(bus.valid_out), 32'd0);
    check({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, ".unf"}, 32'(bus.underflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Fill 0x11..0x18; almost_full from count 6, full at 8.
    for (int i = 0; i < 8; i++) begin
      bus.w_en    = 1'b1;
      bus.data_in = 8'(32'h11 + i);
      tick();
      check($sformatf("fill%0d.count", i), 32'(bus.count), 32'(i + 1));
      check($sformatf("fill%0d.af", i), 32'(bus.almost_full), 32'((i + 1) >= 6));
      check($sformatf("fill%0d.ae", i), 32'(bus.almost_empty), 32'((i + 1) <= 1));
      check($sformatf("fill%0d.full", i), 32'(bus.full), 32'((i + 1) == 8));
    end
    bus.data_in = 8'h99;
    tick();
    check("ovf.pulse", 32'(bus.overflow), 32'd1);
    check("ovf.count", 32'(bus.count), 32'd8);
    bus.w_en = 1'b0;
    tick();
    check("ovf.clear", 32'(bus.overflow), 32'd0);

    // Drain in order, then underflow.
    for (int i = 0; i < 8; i++) begin
      bus.r_en = 1'b1;
      pre_read($sformatf("drain%0d", i), 8'(32'h11 + i));
      tick();
      post_read($sformatf("drain%0d", i), 8'(32'h11 + i));
      check($sformatf("drain%0d.count", i), 32'(bus.count), 32'(7 - i));
    end
    tick();
    check("unf.pulse", 32'(bus.underflow), 32'd1);
    check("unf.empty", 32'(bus.empty), 32'd1);
    check("unf.valid", 32'(bus.valid_out), 32'd0);
    bus.r_en = 1'b0;
    tick();
    check("unf.clear", 32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("unf.hold", 32'(bus.data_out), 32'h18);
`endif

    // Interleaved write/read of 12 words across the pointer wrap.
    bus.w_en    = 1'b1;
    bus.data_in = 8'h40;
    tick();
    for (int i = 1; i < 12; i++) begin
      bus.w_en    = 1'b1;
      bus.r_en    = 1'b1;
      bus.data_in = 8'(32'h40 + i);
      pre_read($sformatf("wrap%0d", i), 8'(32'h40 + i - 1));
      tick();
      post_read($sformatf("wrap%0d", i), 8'(32'h40 + i - 1));
      check($sformatf("wrap%0d.count", i), 32'(bus.count), 32'd1);
      check($sformatf("wrap%0d.full", i), 32'(bus.full), 32'd0);
    end
    bus.w_en = 1'b0;
    pre_read("wrap_last", 8'h4B);
    tick();
    post_read("wrap_last", 8'h4B);
    check("wrap_last.empty", 32'(bus.empty), 32'd1);
    bus.r_en = 1'b0;

    // Full with both requests: read accepted, write refused.
    for (int i = 0; i < 8; i++) begin
      bus.w_en    = 1'b1;
      bus.data_in = 8'(32'h50 + i);
      tick();
    end
    check("both_full.pre_full", 32'(bus.full), 32'd1);
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h99;
    pre_read("both_full", 8'h50);
    tick();
    post_read("both_full", 8'h50);
    check("both_full.count", 32'(bus.count), 32'd7);
    check("both_full.ovf", 32'(bus.overflow), 32'd1);
    bus.w_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      pre_read($sformatf("both_full_drain%0d", i), 8'(32'h50 + i));
      tick();
      post_read($sformatf("both_full_drain%0d", i), 8'(32'h50 + i));
    end
    check("both_full_drain.empty", 32'(bus.empty), 32'd1);

    // Empty with both requests: write accepted, read refused.
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h66;
    tick();
    check("both_empty.count", 32'(bus.count), 32'd1);
    check("both_empty.unf", 32'(bus.underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    check("both_empty.valid", 32'(bus.valid_out), 32'd1);
`else
    check("both_empty.valid", 32'(bus.valid_out), 32'd0);
`endif
    bus.w_en = 1'b0;
    pre_read("both_empty_rd", 8'h66);
    tick();
    post_read("both_empty_rd", 8'h66);
    check("both_empty_rd.empty", 32'(bus.empty), 32'd1);
    bus.r_en = 1'b0;

    // Reset mid-operation with both requests asserted.
    for (int i = 0; i < 5; i++) begin
      bus.w_en    = 1'b1;
      bus.data_in = 8'(32'h70 + i);
      tick();
    end
    check("pre_rst.count", 32'(bus.count), 32'd5);
    rst         = 1'b1;
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h77;
    tick();
    check_reset_state("mid_rst");
    rst      = 1'b0;
    bus.r_en = 1'b0;
    bus.data_in = 8'hA5;
    tick();
    bus.w_en = 1'b0;
    check("post_rst.count", 32'(bus.count), 32'd1);
    bus.r_en = 1'b1;
    pre_read("post_rst_rd", 8'hA5);
    tick();
    post_read("post_rst_rd", 8'hA5);
    bus.r_en = 1'b0;
    check("post_rst_rd.empty", 32'(bus.empty), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: word visible right after its write edge, no r_en needed.
    bus.w_en    = 1'b1;
    bus.data_in = 8'h3C;
    tick();
    bus.w_en = 1'b0;
    check("fwft.data", 32'(bus.data_out), 32'h3C);
    check("fwft.empty", 32'(bus.empty), 32'd0);
    tick();
    check("fwft.hold", 32'(bus.data_out), 32'h3C);
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    check("fwft.pop_empty", 32'(bus.empty), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DEPTH, 2048, number of storage entries; power of two, >= 4.
REQ-002 Parameter DATA_WIDTH, 8, bits per entry.
REQ-003 Parameter AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 w_en  input  1  write request.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 r_en  input  1  read request.
REQ-010 data_out  output  DATA_WIDTH  read data.
REQ-011 valid_out  output  1  data_out holds a newly popped word (standard mode only).
REQ-012 full, empty  output  1 each  occupancy flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-016 Pointers SHALL be $clog2(DEPTH)+1 bits wide; all DEPTH entries usable.
REQ-017 full SHALL equal (pointer MSBs differ, lower bits equal); empty SHALL equal (pointers identical).
REQ-018 count SHALL equal w_ptr - r_ptr modulo 2^($clog2(DEPTH)+1); flags derive combinationally from registered pointers.
REQ-019 Write accepted iff w_en && !full; entry at w_ptr written, w_ptr increments, wraps naturally.
REQ-020 Read accepted iff r_en && !empty; r_ptr increments, wraps naturally.
REQ-021 Full and simultaneous r_en: read accepted, write refused (full sampled before the edge).
REQ-022 Empty and simultaneous w_en: write accepted, read refused.
REQ-023 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-024 overflow SHALL pulse high for one cycle following any w_en while full; underflow likewise for r_en while empty; state otherwise unchanged.
REQ-025 Write at edge N SHALL make the word readable (empty low) from edge N onward, i.e. flags update in the cycle after the write edge.

Reset
REQ-026 rst SHALL take priority over w_en and r_en in the same cycle.
REQ-027 On reset: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, data_out 0, valid_out 0, overflow 0, underflow 0.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-operation SHALL discard all stored words; first post-reset read returns first post-reset write.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-031 Without it (standard): data_out registered, loaded with head entry on accepted read, visible one cycle after r_en; holds otherwise; valid_out high exactly the cycle after each accepted read.
REQ-032 With it (FWFT): data_out combinationally shows head entry whenever empty is low; r_en acknowledges/pops; valid_out tied to !empty; no read latency.
REQ-033 Pointer, flag, count and error behaviour SHALL be identical in both modes.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1)
REQ-034 Reset, then write 0x11..0x18 -> count 8, full 1, almost_full 1 from count 6; ninth write -> overflow pulse, count stays 8.
REQ-035 Fill 8, read 8 -> data 0x11..0x18 in order (standard: each one cycle after r_en with valid_out); then r_en -> underflow pulse, empty 1.
REQ-036 Write 12 / read 12 interleaved across wrap -> every word returned in order, no loss, full never falsely asserted.
REQ-037 Full with r_en and w_en together -> read accepted, write refused, count 7; empty with both -> write accepted, count 1.
REQ-038 Count 5, assert rst with w_en and r_en -> next cycle count 0, empty 1, all outputs at reset values; write 0xA5 then read -> 0xA5.
REQ-039 FWFT build: write 0x3C at edge N -> data_out 0x3C and empty 0 after edge N with no r_en; r_en pops it, empty 1 next cycle.
